// File: rtl/sync_fifo_prefetch_param_if.sv
// Handshake and status bundle for the prefetching synchronous FIFO.
// The master side is the user, and the slave side is the FIFO itself.
interface sync_fifo_prefetch_param_if #(
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH_WIDTH = 11
);
   logic                   clr;
   logic                   wr_en;
   logic [DATA_WIDTH-1:0]  wr_data;
   logic                   wr_vld;
   logic                   rd_en;
   logic [DATA_WIDTH-1:0]  rd_data;
   logic                   rd_vld;
   logic [DEPTH_WIDTH:0]   level;
   logic                   almost_full;
   logic                   almost_empty;
   logic                   overflow;
   logic                   underflow;

   modport master (
      output clr, wr_en, wr_data, rd_en,
      input  wr_vld, rd_data, rd_vld, level,
             almost_full, almost_empty, overflow, underflow
   );

   modport slave (
      input  clr, wr_en, wr_data, rd_en,
      output wr_vld, rd_data, rd_vld, level,
             almost_full, almost_empty, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_prefetch_param.sv
// Synchronous FIFO with a first-word-fall-through output register. The head entry
// lives in rd_data and the remaining entries live in the RAM. Both count toward level.
module sync_fifo_prefetch_param #(
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH_WIDTH = 11,
   parameter int AFULL_TH    = (1 << DEPTH_WIDTH) - 4,
   parameter int AEMPTY_TH   = 4
) (
   input logic                       clk,
   input logic                       rst_n,
   sync_fifo_prefetch_param_if.slave bus
);

   localparam int DEPTH = 1 << DEPTH_WIDTH;

   typedef logic [DEPTH_WIDTH-1:0] ptr_t;
   typedef logic [DEPTH_WIDTH:0]   lvl_t;

   localparam lvl_t DEPTH_LVL  = lvl_t'(DEPTH);
   localparam lvl_t AFULL_LVL  = lvl_t'(AFULL_TH);
   localparam lvl_t AEMPTY_LVL = lvl_t'(AEMPTY_TH);

   logic [DATA_WIDTH-1:0] ram [DEPTH];
   ptr_t                  wr_ptr;
   ptr_t                  rd_ptr;
   lvl_t                  level;
   logic                  rd_vld;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  overflow;
   logic                  underflow;

   logic wr_vld;
   logic wr_acc;
   logic pop;
   logic ram_empty;
   logic out_free;
   logic ram_rd;
   logic bypass;
   logic ram_we;

   assign wr_vld = (level < DEPTH_LVL);

   // NOTE: every signal gets a default at the top of always_comb, so no path can infer a latch.
   always_comb begin
      wr_acc    = 1'b0;
      pop       = 1'b0;
      ram_rd    = 1'b0;
      bypass    = 1'b0;
      ram_we    = 1'b0;
      ram_empty = (wr_ptr == rd_ptr);
      out_free  = !rd_vld;
      if (!bus.clr) begin
         wr_acc   = bus.wr_en && wr_vld;
         pop      = bus.rd_en && rd_vld;
         out_free = !rd_vld || pop;
         // An empty RAM lets a write go straight into the output stage (one-cycle latency).
         ram_rd   = out_free && !ram_empty;
         bypass   = out_free && ram_empty && wr_acc;
         ram_we   = wr_acc && !bypass;
      end
   end

   // NOTE: the storage array has no reset, so it can map onto RAM. Nothing reads a slot before it is written.
   always_ff @(posedge clk) begin
      if (ram_we) ram[wr_ptr] <= bus.wr_data;
   end

   // NOTE: all sequential state uses non-blocking assignments, which avoids ordering races between processes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         rd_vld    <= 1'b0;
         rd_data   <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (bus.clr) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         rd_vld    <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (ram_we) wr_ptr <= wr_ptr + ptr_t'(1);
         if (ram_rd) begin
            rd_data <= ram[rd_ptr];
            rd_ptr  <= rd_ptr + ptr_t'(1);
            rd_vld  <= 1'b1;
         end else if (bypass) begin
            rd_data <= bus.wr_data;
            rd_vld  <= 1'b1;
         end else if (pop) begin
            rd_vld  <= 1'b0;
         end
         case ({wr_acc, pop})
            2'b10:   level <= level + lvl_t'(1);
            2'b01:   level <= level - lvl_t'(1);
            default: level <= level;
         endcase
         if (bus.wr_en && !wr_vld) overflow  <= 1'b1;
         if (bus.rd_en && !rd_vld) underflow <= 1'b1;
      end
   end

   assign bus.wr_vld       = wr_vld;
   assign bus.rd_vld       = rd_vld;
   assign bus.rd_data      = rd_data;
   assign bus.level        = level;
   assign bus.almost_full  = (level >= AFULL_LVL);
   assign bus.almost_empty = (level <= AEMPTY_LVL);
   assign bus.overflow     = overflow;
   assign bus.underflow    = underflow;

endmodule

// File: tb/tb_sync_fifo_prefetch_param.sv
// Self-checking bench for sync_fifo_prefetch_param (32-bit data, 16 entries).
// A queue-based model is compared with the DUT after every clock edge.
module tb_sync_fifo_prefetch_param;
   localparam int DW    = 32;
   localparam int AW    = 4;
   localparam int DEPTH = 16;
   localparam int AF    = 12;
   localparam int AE    = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   sync_fifo_prefetch_param_if #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW)) bus ();

   sync_fifo_prefetch_param #(
      .DATA_WIDTH(DW), .DEPTH_WIDTH(AW), .AFULL_TH(AF), .AEMPTY_TH(AE)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic        clr;
      logic        wr_en;
      logic [31:0] wr_data;
      logic        rd_en;
      int          exp_level;
      logic        exp_rd_vld;
      logic [31:0] exp_rd_data;
      logic        exp_ovf;
      logic        exp_udf;
   } vec_t;

   int passed = 0;
   int total  = 0;

   logic [31:0] q[$];
   bit          m_ovf;
   bit          m_udf;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic compare_model(input string tag);
      int n;
      n = q.size();
      check({tag, " level"},        64'(bus.level),    64'(n));
      check({tag, " rd_vld"},       64'(bus.rd_vld),   64'(n > 0));
      if (n > 0) check({tag, " rd_data"}, 64'(bus.rd_data), 64'(q[0]));
      check({tag, " wr_vld"},       64'(bus.wr_vld),   64'(n < DEPTH));
      check({tag, " almost_full"},  64'(bus.almost_full),  64'(n >= AF));
      check({tag, " almost_empty"}, 64'(bus.almost_empty), 64'(n <= AE));
      check({tag, " overflow"},     64'(bus.overflow),  64'(m_ovf));
      check({tag, " underflow"},    64'(bus.underflow), 64'(m_udf));
   endtask

   // One clock: drive inputs, advance the model from the pre-edge contents, then compare after the edge.
   task automatic cycle(input logic c, input logic we, input logic [31:0] wd,
                        input logic re, input string tag);
      bit can_wr, can_rd;
      bus.clr     = c;
      bus.wr_en   = we;
      bus.wr_data = wd;
      bus.rd_en   = re;
      if (c) begin
         q.delete();
         m_ovf = 0;
         m_udf = 0;
      end else begin
         can_wr = q.size() < DEPTH;
         can_rd = q.size() > 0;
         if (we && !can_wr) m_ovf = 1;
         if (re && !can_rd) m_udf = 1;
         if (re && can_rd) void'(q.pop_front());
         if (we && can_wr) q.push_back(wd);
      end
      @(posedge clk);
      #1;
      compare_model(tag);
   endtask

   vec_t tbl[7];

   initial begin
      int wp;
      int rp;

      tbl[0] = '{1'b0, 1'b1, 32'hA5A5A5A5, 1'b0, 1, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 1'b0, 32'h0,        1'b1, 0, 1'b0, 32'h0,        1'b0, 1'b0};
      tbl[2] = '{1'b0, 1'b0, 32'h0,        1'b1, 0, 1'b0, 32'h0,        1'b0, 1'b1};
      tbl[3] = '{1'b0, 1'b1, 32'h11,       1'b1, 1, 1'b1, 32'h11,       1'b0, 1'b1};
      tbl[4] = '{1'b0, 1'b1, 32'h22,       1'b0, 2, 1'b1, 32'h11,       1'b0, 1'b1};
      tbl[5] = '{1'b0, 1'b1, 32'h33,       1'b1, 2, 1'b1, 32'h22,       1'b0, 1'b1};
      tbl[6] = '{1'b1, 1'b1, 32'h44,       1'b1, 0, 1'b0, 32'h0,        1'b0, 1'b0};

      rst_n       = 1'b0;
      bus.clr     = 1'b0;
      bus.wr_en   = 1'b0;
      bus.wr_data = '0;
      bus.rd_en   = 1'b0;
      m_ovf = 0;
      m_udf = 0;
      #12;
      compare_model("reset");
      check("reset rd_data", 64'(bus.rd_data), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) begin
         cycle(tbl[i].clr, tbl[i].wr_en, tbl[i].wr_data, tbl[i].rd_en, $sformatf("vec%0d", i));
         check($sformatf("vec%0d tbl level", i),  64'(bus.level),     64'(tbl[i].exp_level));
         check($sformatf("vec%0d tbl rd_vld", i), 64'(bus.rd_vld),    64'(tbl[i].exp_rd_vld));
         if (tbl[i].exp_rd_vld)
            check($sformatf("vec%0d tbl rd_data", i), 64'(bus.rd_data), 64'(tbl[i].exp_rd_data));
         check($sformatf("vec%0d tbl overflow", i),  64'(bus.overflow),  64'(tbl[i].exp_ovf));
         check($sformatf("vec%0d tbl underflow", i), 64'(bus.underflow), 64'(tbl[i].exp_udf));
      end

      // Fill to full with 0x1..0x10.
      for (int i = 1; i <= 16; i++) begin
         cycle(1'b0, 1'b1, 32'(i), 1'b0, $sformatf("fill%0d", i));
         if (i == 11) check("af below threshold", 64'(bus.almost_full), 64'h0);
         if (i == 12) check("af at threshold",    64'(bus.almost_full), 64'h1);
      end
      check("full wr_vld", 64'(bus.wr_vld), 64'h0);
      check("full level",  64'(bus.level),  64'd16);

      // At full, a simultaneous write and pop pops only.
      cycle(1'b0, 1'b1, 32'hDEAD, 1'b1, "full_wr_rd");
      check("full_wr_rd level",    64'(bus.level),    64'd15);
      check("full_wr_rd overflow", 64'(bus.overflow), 64'h1);
      check("full_wr_rd head",     64'(bus.rd_data),  64'h2);

      // Drain to level 8, then stream across the pointer wrap.
      for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, "drain");
      check("drain level", 64'(bus.level), 64'd8);
      for (int i = 0; i < 40; i++) begin
         cycle(1'b0, 1'b1, 32'(32'h100 + i), 1'b1, $sformatf("stream%0d", i));
         check($sformatf("stream%0d no gap", i), 64'(bus.rd_vld), 64'h1);
      end

      // Reach level 10 with overflow still set, then flush while writing.
      cycle(1'b0, 1'b1, 32'h201, 1'b0, "to10a");
      cycle(1'b0, 1'b1, 32'h202, 1'b0, "to10b");
      check("pre_clr level",    64'(bus.level),    64'd10);
      check("pre_clr overflow", 64'(bus.overflow), 64'h1);
      cycle(1'b1, 1'b1, 32'h203, 1'b0, "clr");
      check("clr level",    64'(bus.level),    64'h0);
      check("clr rd_vld",   64'(bus.rd_vld),   64'h0);
      check("clr overflow", 64'(bus.overflow), 64'h0);

      // Asynchronous reset in the middle of a write burst.
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 32'(32'h300 + i), 1'b0, "burst");
      bus.wr_en = 1'b1;
      @(posedge clk);
      #3;
      rst_n     = 1'b0;
      bus.wr_en = 1'b0;
      q.delete();
      m_ovf = 0;
      m_udf = 0;
      #1;
      compare_model("async_rst");
      check("async_rst rd_data", 64'(bus.rd_data), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1'b0, 1'b1, 32'hBEEF, 1'b0, "post_rst");
      check("post_rst head", 64'(bus.rd_data), 64'hBEEF);

      // Random traffic with changing write and read bias and occasional flushes.
      wp = 50;
      rp = 50;
      for (int i = 0; i < 3000; i++) begin
         if (i % 500 == 0) begin
            wp = $urandom_range(20, 90);
            rp = $urandom_range(20, 90);
         end
         cycle(($urandom_range(0, 99) == 0),
               ($urandom_range(0, 99) < wp), $urandom,
               ($urandom_range(0, 99) < rp), $sformatf("rnd%0d", i));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/sync_fifo_prefetch_param.md
SYNC_FIFO_PREFETCH_PARAM -- requirements
Module: sync_fifo_prefetch_param

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, meaning width of wr_data/rd_data (legal 1..1152).
REQ-002 SHALL provide parameter DEPTH_WIDTH, default 11, meaning log2 of capacity; DEPTH = 2^DEPTH_WIDTH entries (legal 4..16).
REQ-003 SHALL provide parameter AFULL_TH, default DEPTH-4, meaning level at or above which almost_full asserts (legal 1..DEPTH).
REQ-004 SHALL provide parameter AEMPTY_TH, default 4, meaning level at or below which almost_empty asserts (legal 0..DEPTH-1).
REQ-005 SHALL provide clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-006 SHALL provide rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL provide clr, input, 1 bit: synchronous flush.
REQ-008 SHALL provide wr_en, input, 1 bit: write request.
REQ-009 SHALL provide wr_data, input, DATA_WIDTH: write data.
REQ-010 SHALL provide wr_vld, output, 1 bit: space available; a write is accepted when wr_en && wr_vld.
REQ-011 SHALL provide rd_en, input, 1 bit: pop request.
REQ-012 SHALL provide rd_data, output, DATA_WIDTH: head-of-queue data (prefetch, first-word-fall-through).
REQ-013 SHALL provide rd_vld, output, 1 bit: rd_data holds valid head; a pop occurs when rd_en && rd_vld.
REQ-014 SHALL provide level, output, DEPTH_WIDTH+1: number of stored entries, including the prefetch output stage.
REQ-015 SHALL provide almost_full, almost_empty, overflow and underflow, each output, 1 bit.

Function
REQ-016 SHALL hold exactly DEPTH entries in total, storage RAM plus prefetch output register combined.
REQ-017 SHALL drive wr_vld = (level < DEPTH), decoded from registered state; at full, wr_en is ignored even when rd_en pops in the same cycle (no write-through at full).
REQ-018 SHALL ignore rd_en when rd_vld=0; rd_data is don't-care while rd_vld=0.
REQ-019 SHALL present, when the FIFO is empty, data accepted at edge N on rd_data with rd_vld=1 after edge N (one-cycle write-to-valid latency).
REQ-020 SHALL, on a pop at edge N with further entries queued, present the next entry with rd_vld=1 after edge N, with no bubble.
REQ-021 SHALL keep rd_data and rd_vld stable while rd_vld=1 and rd_en=0.
REQ-022 SHALL preserve strict write order on output.
REQ-023 SHALL wrap write and read pointers modulo DEPTH.
REQ-024 SHALL update level by +1 on a write only, -1 on a pop only, and 0 on a simultaneous write and pop; level never exceeds DEPTH and never goes below 0.
REQ-025 SHALL drive almost_full = (level >= AFULL_TH) and almost_empty = (level <= AEMPTY_TH), both from the registered level.
REQ-026 SHALL set overflow to a sticky 1 on any cycle with wr_en=1 && wr_vld=0.
REQ-027 SHALL set underflow to a sticky 1 on any cycle with rd_en=1 && rd_vld=0.
REQ-028 SHALL, on clr=1 at edge N, empty the FIFO after edge N (level=0, rd_vld=0, wr_vld=1) and clear overflow and underflow; wr_en and rd_en in that cycle are discarded and do not set the sticky flags.

Reset
REQ-029 SHALL, on rst_n=0, immediately and asynchronously set pointers to 0, level=0, rd_vld=0, wr_vld=1, almost_full=0, almost_empty=1, overflow=0, underflow=0, rd_data=0.
REQ-030 SHALL discard all content on a reset asserted mid-operation; the first write after release follows REQ-019.
REQ-031 SHALL leave RAM contents uninitialised by reset; no output depends on them until rewritten.

Verification
REQ-032 With DATA_WIDTH=32, DEPTH_WIDTH=4: write 0x1..0x10 back-to-back -> wr_vld=0 and level=16 after the 16th accept; almost_full=1 from level 12.
REQ-033 Same configuration, full FIFO: drive wr_en=1, rd_en=1 together -> one pop, no write, level=15, overflow=1.
REQ-034 Empty FIFO: write 0xA5A5A5A5 at edge N -> rd_vld=1 and rd_data=0xA5A5A5A5 after edge N; pop -> rd_vld=0; a further rd_en -> underflow=1.
REQ-035 Level 8: continuous simultaneous write/pop for 40 cycles across pointer wrap -> level stays 8, output order intact, no rd_vld gap.
REQ-036 Level 10 with overflow=1: pulse clr together with wr_en -> level=0, rd_vld=0, overflow=0 next cycle; then assert rst_n=0 mid-burst -> all outputs take reset values immediately.
